fflags_rob_idx_queue_ctrl: RTL
==============================

Name: fflags_rob_idx_queue_ctrl

Overview:
- Pointer, occupancy and handshake controller for the 7-entry x 7-bit fflags rob_idx storage RAM (R0/W0 ports, combinational read).
- Sits between FPU writeback (enqueue: rob_idx of a uop raising fflags) and the ROB fflags-commit logic (dequeue, in order).
- Presents a ready/valid queue; drives RAM write/read address and enables; supports full flush on pipeline kill.

Parameters:
- DEPTH, 7, number of RAM entries; legal 2..8 and not required to be a power of two.
- AW, 3, address width; must satisfy 2**AW >= DEPTH.
- DW, 7, rob_idx width; equals the RAM data width.

Ports:
- clock  in  1  single clock for all state and for both RAM ports.
- reset_n  in  1  synchronous, active-low reset.
- enq_valid  in  1  producer has a rob_idx to push.
- enq_ready  out  1  queue accepts an entry this cycle.
- enq_bits  in  DW  rob_idx to store.
- deq_valid  out  1  head entry is valid.
- deq_ready  in  1  consumer takes the head this cycle.
- deq_bits  out  DW  head rob_idx; forwarded from ram_R0_data.
- flush  in  1  discard all entries.
- count  out  AW+1  current occupancy, 0..DEPTH.
- ram_W0_addr  out  AW  write pointer (tail).
- ram_W0_en  out  1  high exactly when an enqueue fires.
- ram_W0_data  out  DW  equals enq_bits.
- ram_R0_addr  out  AW  read pointer (head).
- ram_R0_en  out  1  equals deq_valid.
- ram_R0_data  in  DW  RAM read data, combinational from ram_R0_addr.

Behaviour:
- State: head, tail (AW bits each); count (AW+1 bits).
- Reset (reset_n low at a clock edge): head = tail = 0, count = 0.
  - Outputs then read deq_valid = 0, enq_ready = 1, ram_W0_en = 0, ram_R0_en = 0.
  - Reset overrides flush and any handshake in the same cycle.
- Handshake signals:
  - enq_ready = (count != DEPTH); enq_fire = enq_valid & enq_ready.
  - deq_valid = (count != 0); deq_fire = deq_valid & deq_ready.
  - deq_bits is valid in the same cycle, with zero latency.
- Write latency: an entry enqueued at edge N is visible on deq no earlier than cycle N+1. There is no enq-to-deq bypass when empty.
- Pointer wrap: increment is (ptr == DEPTH-1) ? 0 : ptr+1. Addresses DEPTH..2**AW-1 are never driven.
- Occupancy update: count += enq_fire - deq_fire. A simultaneous enqueue and dequeue leaves count unchanged and advances both pointers.
- Boundaries:
  - Full (count == DEPTH): enq_ready = 0, so enqueue is blocked even if dequeue fires in the same cycle (base build).
  - Empty: a deq_ready with no valid entry is ignored.
- Flush: next state is head = tail = 0, count = 0.
  - ram_W0_en is forced to 0 in the flush cycle, so no write is accepted.
  - enq_ready still reflects the pre-flush count; a handshake in that cycle is dropped by definition and the producer is notified via flush.
- RAM contents are never cleared. Stale data is unreachable because deq_valid gates every read.

Optional Feature:
- Macro: FFLAGS_ROB_IDX_QUEUE_PIPE_EN.
- Defined: enq_ready = (count != DEPTH) | deq_ready. When full and the consumer dequeues, a new enqueue fires in the same cycle: it writes to slot tail (== head), and count stays DEPTH. The RAM must return the old head data combinationally in that cycle (the read occurs before the write edge).
- Undefined: base rule enq_ready = (count != DEPTH). Creates no combinational path from deq_ready to enq_ready.

Decomposition:
- Package fflags_queue_pkg holds:
  - localparams FFQ_DEPTH = 7, FFQ_AW = 3, FFQ_DW = 7;
  - typedef logic [FFQ_AW-1:0] ffq_ptr_t;
  - typedef logic [FFQ_DW-1:0] rob_idx_t;
  - function ffq_ptr_inc (modulo-DEPTH increment).
- Sub-module: none. The two pointers are identical counters built with ffq_ptr_inc; the RAM is instantiated by the parent and connected through the ram_* ports.

Test Plan:
- Reset then idle: hold reset_n = 0 for 2 cycles, release → count = 0, deq_valid = 0, enq_ready = 1, ram_W0_en = 0.
- Fill and drain: enqueue 7 values 0x10..0x16 back-to-back.
  - After the 7th: count = 7, enq_ready = 0, and an 8th enq_valid writes nothing.
  - Drain: deq_bits = 0x10..0x16 in order, then deq_valid = 0.
- Wrap-around: enqueue 5, dequeue 5, then enqueue 0x20..0x23 → ram_W0_addr sequence 5,6,0,1; deq_bits = 0x20..0x23 in order.
- Simultaneous enq/deq at count = 3 for 10 cycles → count stays 3; head and tail both advance 10 mod 7 = 3 positions; data order preserved.
- Flush with enq_valid = 1 at count = 4 → next cycle count = 0, head = tail = 0, no write in the flush cycle; a following enqueue of 0x3F lands at address 0.
- Full-with-dequeue: at count = 7 assert enq_valid = 1 and deq_ready = 1.
  - Base: no write; count = 6.
  - With FFLAGS_ROB_IDX_QUEUE_PIPE_EN: write to the old head slot; count = 7; deq_bits is the old head.

Source files
------------

// File: rtl/fflags_queue_pkg.sv
// -----------------------------------------------------------------------------
// fflags_queue_pkg
//   Shared types and helpers for the fflags rob_idx queue controller.
//   - FFQ_DEPTH / FFQ_AW / FFQ_DW : default geometry of the rob_idx RAM
//   - ffq_ptr_t                   : RAM address / queue pointer type
//   - rob_idx_t                   : stored ROB index type
//   - ffq_ptr_inc()               : modulo-depth pointer increment; depth need
//                                   not be a power of two
// -----------------------------------------------------------------------------
package fflags_queue_pkg;

    localparam int FFQ_DEPTH = 7;
    localparam int FFQ_AW    = 3;
    localparam int FFQ_DW    = 7;

    typedef logic [FFQ_AW-1:0] ffq_ptr_t;
    typedef logic [FFQ_DW-1:0] rob_idx_t;

    // Wraps from depth-1 back to 0, so addresses depth..2**AW-1 are never
    // produced.
    function automatic ffq_ptr_t ffq_ptr_inc(input ffq_ptr_t    ptr,
                                             input int unsigned depth = FFQ_DEPTH);
        return (32'(ptr) == depth - 1) ? '0 : ptr + ffq_ptr_t'(1);
    endfunction

endpackage

// File: rtl/fflags_rob_idx_queue_ctrl.sv
// -----------------------------------------------------------------------------
// fflags_rob_idx_queue_ctrl
//   Pointer / occupancy / handshake controller for the fflags rob_idx RAM.
//   FPU writeback pushes the rob_idx of each uop that raised fflags; the ROB
//   fflags-commit logic pops them in order. The RAM itself lives in the
//   parent and is reached through the ram_* ports (combinational read).
//
// Ports
//   clock, reset_n          : clock; synchronous active-low reset
//   enq_valid/ready/bits    : producer side (ready/valid)
//   deq_valid/ready/bits    : consumer side; deq_bits = ram_R0_data
//   flush                   : discard all entries (pipeline kill)
//   count                   : occupancy 0..DEPTH
//   ram_W0_addr/en/data     : RAM write port (tail)
//   ram_R0_addr/en/data     : RAM read port (head)
//
// Build option
//   FFLAGS_ROB_IDX_QUEUE_PIPE_EN : when defined, a full queue still accepts an
//   enqueue in a cycle where the head is being dequeued (enq_ready depends on
//   deq_ready). Undefined, enq_ready depends on count only.
// -----------------------------------------------------------------------------
module fflags_rob_idx_queue_ctrl
    import fflags_queue_pkg::*;
#(
    parameter int DEPTH = FFQ_DEPTH,
    parameter int AW    = FFQ_AW,
    parameter int DW    = FFQ_DW
) (
    input  logic          clock,
    input  logic          reset_n,

    input  logic          enq_valid,
    output logic          enq_ready,
    input  logic [DW-1:0] enq_bits,

    output logic          deq_valid,
    input  logic          deq_ready,
    output logic [DW-1:0] deq_bits,

    input  logic          flush,
    output logic [AW:0]   count,

    output logic [AW-1:0] ram_W0_addr,
    output logic          ram_W0_en,
    output logic [DW-1:0] ram_W0_data,
    output logic [AW-1:0] ram_R0_addr,
    output logic          ram_R0_en,
    input  logic [DW-1:0] ram_R0_data
);

    logic [AW-1:0] head_q, tail_q;
    logic [AW-1:0] head_d, tail_d;
    logic [AW:0]   count_q, count_d;
    logic          full, empty;
    logic          enq_fire, deq_fire;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);

`ifdef FFLAGS_ROB_IDX_QUEUE_PIPE_EN
    // When full, the slot being written is the head being read this cycle;
    // the RAM returns the old data combinationally before the write edge.
    assign enq_ready = ~full | deq_ready;
`else
    assign enq_ready = ~full;
`endif

    assign deq_valid = ~empty;
    assign deq_fire  = deq_valid & deq_ready;
    // A flush drops any handshake in its cycle; the producer learns of it
    // through flush itself, so enq_ready is not masked.
    assign enq_fire  = enq_valid & enq_ready & ~flush;

    assign deq_bits    = ram_R0_data;
    assign ram_R0_addr = head_q;
    assign ram_R0_en   = deq_valid;
    assign ram_W0_addr = tail_q;
    assign ram_W0_en   = enq_fire;
    assign ram_W0_data = enq_bits;
    assign count       = count_q;

    // NOTE: every combinationally assigned variable gets a default at the top
    // of the block so no path leaves it unassigned (no latch inference).
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_fire) tail_d = AW'(ffq_ptr_inc(ffq_ptr_t'(tail_q), DEPTH));
            if (deq_fire) head_d = AW'(ffq_ptr_inc(ffq_ptr_t'(head_q), DEPTH));
            case ({enq_fire, deq_fire})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering. The RAM contents are
    // deliberately never reset: deq_valid gates every read, so stale data is
    // unreachable.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule
